tiny45_load_store: RTL and testbench

Load/store unit directly downstream of tiny45_core. It captures the nibble-serial core's load/store address and store data from the core's `data_out`, and runs one 32-bit transaction on a simple valid/ready memory bus. For loads, it byte-aligns and extends the read word, then streams it back into the core as 8 nibbles through `data_in`/`load_data_ready`, aligned to the core's sub-cycle counter.

---
 rtl/tiny45_pkg.sv | 53 +++++
 rtl/tiny45_load_align.sv | 48 ++++
 rtl/tiny45_load_store.sv | 165 ++++++++++++++++
 tb/tb_tiny45_load_store.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/tiny45_pkg.sv
// Shared definitions for the tiny45 load/store path: funct3 encodings,
// LSU state encoding, access-size decode and alignment helpers.
package tiny45_pkg;

    localparam int NIBBLE_W = 4;
    localparam int WORD_W   = 32;
    localparam int NIBBLES  = WORD_W / NIBBLE_W;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACAP    = 3'd1,
        ST_SWAIT   = 3'd2,
        ST_SCAP    = 3'd3,
        ST_SDROP   = 3'd4,
        ST_BUS     = 3'd5,
        ST_LWAIT   = 3'd6,
        ST_LSTREAM = 3'd7
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } mem_size_e;

    // Unused funct3 codes (011, 11x) fall back to a full word access.
    function automatic mem_size_e op_size(input logic [2:0] op);
        mem_size_e sz;
        case (op)
            MEM_B, MEM_BU: sz = SZ_B;
            MEM_H, MEM_HU: sz = SZ_H;
            default:       sz = SZ_W;
        endcase
        return sz;
    endfunction

    function automatic logic addr_misaligned(input logic [2:0] op, input logic [1:0] a);
        logic mis;
        case (op_size(op))
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = a[0];
            default: mis = (a != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/tiny45_load_align.sv
// Byte-lane steering: extends read data by size/sign and builds the
// write strobes and lane-replicated write data for stores.
module tiny45_load_align
    import tiny45_pkg::*;
(
    input  logic [WORD_W-1:0] i_rdata,
    input  logic [WORD_W-1:0] i_sdata,
    input  logic [1:0]        i_addr_lo,
    input  logic [2:0]        i_mem_op,
    output logic [WORD_W-1:0] o_load_word,
    output logic [3:0]        o_wstrb,
    output logic [WORD_W-1:0] o_wdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_signed;

    // Lane select, extension and store replication for the decoded size.
    always_comb begin
        w_signed = ~i_mem_op[2];
        w_half   = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        case (op_size(i_mem_op))
            SZ_B: begin
                o_load_word = {{24{w_signed & w_byte[7]}}, w_byte};
                o_wstrb     = 4'b0001 << i_addr_lo;
                o_wdata     = {4{i_sdata[7:0]}};
            end
            SZ_H: begin
                o_load_word = {{16{w_signed & w_half[15]}}, w_half};
                o_wstrb     = 4'b0011 << i_addr_lo;
                o_wdata     = {2{i_sdata[15:0]}};
            end
            default: begin
                o_load_word = i_rdata;
                o_wstrb     = 4'b1111;
                o_wdata     = i_sdata;
            end
        endcase
    end

endmodule

// File: rtl/tiny45_load_store.sv
// Load/store unit behind the nibble-serial tiny45 core: captures address and
// store data from the core, runs one bus transaction, streams loads back.
module tiny45_load_store
    import tiny45_pkg::*;
#(
    parameter int ADDR_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [2:0]           counter,
    input  logic                 address_ready,
    input  logic                 is_load,
    input  logic                 is_store,
    input  logic                 instr_complete,
    input  logic [2:0]           mem_op,
    input  logic [31:0]          core_data,
    output logic [3:0]           data_in,
    output logic                 load_data_ready,
    output logic                 bus_valid,
    output logic                 bus_we,
    output logic [ADDR_BITS-1:0] bus_addr,
    output logic [3:0]           bus_wstrb,
    output logic [31:0]          bus_wdata,
    input  logic                 bus_ready,
    input  logic [31:0]          bus_rdata,
    output logic                 busy,
    output logic                 err
);

    lsu_state_e           r_state;
    lsu_state_e           w_next_state;
    logic [2:0]           r_op;
    logic                 r_is_load;
    logic [ADDR_BITS-1:0] r_addr;
    logic [31:0]          r_sdata;
    logic [31:0]          r_word;
    logic                 r_err;

    logic                 w_mis;
    logic                 w_st_done;
    logic [31:0]          w_load_word;
    logic [3:0]           w_wstrb;
    logic [31:0]          w_wdata;

    assign w_mis     = addr_misaligned(r_op, core_data[1:0]);
    assign w_st_done = instr_complete & is_store;

    tiny45_load_align u_align (
        .i_rdata     (bus_rdata),
        .i_sdata     (r_sdata),
        .i_addr_lo   (r_addr[1:0]),
        .i_mem_op    (r_op),
        .o_load_word (w_load_word),
        .o_wstrb     (w_wstrb),
        .o_wdata     (w_wdata)
    );

    // State register, capture registers and the err pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_op      <= 3'b000;
            r_is_load <= 1'b0;
            r_addr    <= '0;
            r_sdata   <= 32'h0000_0000;
            r_word    <= 32'h0000_0000;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_err   <= (address_ready && (r_state != ST_IDLE)) ||
                       ((r_state == ST_ACAP) && w_mis);
            case (r_state)
                ST_IDLE: begin
                    if (address_ready) begin
                        r_op      <= mem_op;
                        r_is_load <= is_load;
                    end
                end
                ST_ACAP: begin
                    r_addr <= core_data[ADDR_BITS-1:0];
                    if (w_mis) begin
                        r_word <= 32'h0000_0000;
                    end
                end
                ST_SCAP: r_sdata <= core_data;
                ST_BUS: begin
                    if (bus_ready && r_is_load) begin
                        r_word <= w_load_word;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state logic; a store may complete while its address is still being captured.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (address_ready) w_next_state = ST_ACAP;
                else               w_next_state = ST_IDLE;
            end
            ST_ACAP: begin
                if (w_mis) begin
                    if (r_is_load)      w_next_state = ST_LWAIT;
                    else if (w_st_done) w_next_state = ST_IDLE;
                    else                w_next_state = ST_SDROP;
                end else begin
                    if (r_is_load)      w_next_state = ST_BUS;
                    else if (w_st_done) w_next_state = ST_SCAP;
                    else                w_next_state = ST_SWAIT;
                end
            end
            ST_SWAIT: begin
                if (w_st_done) w_next_state = ST_SCAP;
                else           w_next_state = ST_SWAIT;
            end
            ST_SCAP: w_next_state = ST_BUS;
            ST_SDROP: begin
                if (w_st_done) w_next_state = ST_IDLE;
                else           w_next_state = ST_SDROP;
            end
            ST_BUS: begin
                if (!bus_ready)     w_next_state = ST_BUS;
                else if (r_is_load) w_next_state = ST_LWAIT;
                else                w_next_state = ST_IDLE;
            end
            ST_LWAIT: begin
                if (counter == 3'd7) w_next_state = ST_LSTREAM;
                else                 w_next_state = ST_LWAIT;
            end
            ST_LSTREAM: begin
                if (counter == 3'd7) w_next_state = ST_IDLE;
                else                 w_next_state = ST_LSTREAM;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Outputs decoded from registered state; bus fields are zero outside BUS.
    always_comb begin
        busy            = (r_state != ST_IDLE);
        err             = r_err;
        bus_valid       = (r_state == ST_BUS);
        load_data_ready = (r_state == ST_LSTREAM);
        if (bus_valid) begin
            bus_we    = ~r_is_load;
            bus_addr  = {r_addr[ADDR_BITS-1:2], 2'b00};
            bus_wstrb = r_is_load ? 4'b0000 : w_wstrb;
            bus_wdata = r_is_load ? 32'h0000_0000 : w_wdata;
        end else begin
            bus_we    = 1'b0;
            bus_addr  = '0;
            bus_wstrb = 4'b0000;
            bus_wdata = 32'h0000_0000;
        end
        if (load_data_ready) begin
            data_in = r_word[{counter, 2'b00} +: 4];
        end else begin
            data_in = 4'h0;
        end
    end

endmodule

// File: tb/tb_tiny45_load_store.sv
// Directed bench for tiny45_load_store: core-side strobes and a hand-driven
// bus slave, with expected values worked out by hand.
module tb_tiny45_load_store;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [2:0]  counter = 3'd0;
    logic        address_ready = 1'b0;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic        instr_complete = 1'b0;
    logic [2:0]  mem_op = 3'b000;
    logic [31:0] core_data = 32'h0;
    logic [3:0]  data_in;
    logic        load_data_ready;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_ready = 1'b0;
    logic [31:0] bus_rdata = 32'h0;
    logic        busy;
    logic        err;

    int n_vec = 0;
    int n_err = 0;

    tiny45_load_store #(.ADDR_BITS(32)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .counter         (counter),
        .address_ready   (address_ready),
        .is_load         (is_load),
        .is_store        (is_store),
        .instr_complete  (instr_complete),
        .mem_op          (mem_op),
        .core_data       (core_data),
        .data_in         (data_in),
        .load_data_ready (load_data_ready),
        .bus_valid       (bus_valid),
        .bus_we          (bus_we),
        .bus_addr        (bus_addr),
        .bus_wstrb       (bus_wstrb),
        .bus_wdata       (bus_wdata),
        .bus_ready       (bus_ready),
        .bus_rdata       (bus_rdata),
        .busy            (busy),
        .err             (err)
    );

    always #5 clk = ~clk;

    // Core sub-cycle counter runs freely, one step per clock.
    always @(posedge clk) counter <= counter + 3'd1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue a load, serve it after 'stall' wait cycles, then collect the nibble window.
    task automatic do_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] rdata, input int stall, input bit ovr,
                           input logic [31:0] exp_addr, input logic [31:0] exp_word);
        logic [31:0] got;
        int n_hi;
        int w;
        @(negedge clk);
        address_ready = 1'b1; is_load = 1'b1; mem_op = op;
        @(negedge clk);
        address_ready = 1'b0; core_data = addr;
        @(negedge clk);
        check_eq({tag, "_valid"}, {31'b0, bus_valid}, 32'd1);
        check_eq({tag, "_addr"}, bus_addr, exp_addr);
        check_eq({tag, "_we_strb"}, {27'b0, bus_we, bus_wstrb}, 32'h0);
        address_ready = ovr;
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            address_ready = 1'b0;
            if (ovr && k == 0) check_eq({tag, "_ovr_err"}, {31'b0, err}, 32'd1);
            if (k == stall - 1) check_eq({tag, "_valid_held"}, {31'b0, bus_valid}, 32'd1);
        end
        bus_ready = 1'b1; bus_rdata = rdata;
        @(negedge clk);
        bus_ready = 1'b0; bus_rdata = 32'h0; is_load = 1'b0;
        w = 0;
        while (!load_data_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!load_data_ready) begin
            check_eq({tag, "_ldr_timeout"}, 32'd0, 32'd1);
            return;
        end
        check_eq({tag, "_win_start"}, {29'b0, counter}, 32'd0);
        n_hi = 0; got = 32'h0;
        for (int i = 0; i < 8; i++) begin
            if (load_data_ready) n_hi++;
            got[i*4 +: 4] = data_in;
            @(negedge clk);
        end
        check_eq({tag, "_win_len"}, n_hi, 32'd8);
        check_eq({tag, "_ldr_off"}, {31'b0, load_data_ready}, 32'd0);
        check_eq({tag, "_word"}, got, exp_word);
        check_eq({tag, "_idle"}, {31'b0, busy}, 32'd0);
    endtask

    // Issue a store; misaligned ones must pulse err and never reach the bus.
    task automatic do_store(input string tag, input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] sdata, input int stall, input bit mis,
                            input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                            input logic [31:0] exp_wdata);
        @(negedge clk);
        address_ready = 1'b1; is_store = 1'b1; mem_op = op;
        @(negedge clk);
        address_ready = 1'b0; core_data = addr;
        @(negedge clk);
        check_eq({tag, "_err"}, {31'b0, err}, {31'b0, mis});
        check_eq({tag, "_novalid"}, {31'b0, bus_valid}, 32'd0);
        instr_complete = 1'b1;
        @(negedge clk);
        instr_complete = 1'b0; is_store = 1'b0;
        if (mis) begin
            check_eq({tag, "_err_off"}, {31'b0, err}, 32'd0);
            check_eq({tag, "_drop_idle"}, {30'b0, busy, bus_valid}, 32'd0);
            return;
        end
        core_data = sdata;
        @(negedge clk);
        core_data = 32'h0;
        check_eq({tag, "_valid"}, {31'b0, bus_valid}, 32'd1);
        check_eq({tag, "_addr"}, bus_addr, exp_addr);
        check_eq({tag, "_we_strb"}, {27'b0, bus_we, bus_wstrb}, {27'b0, 1'b1, exp_strb});
        check_eq({tag, "_wdata"}, bus_wdata, exp_wdata);
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            if (k == stall - 1) check_eq({tag, "_valid_held"}, {31'b0, bus_valid}, 32'd1);
        end
        bus_ready = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0;
        check_eq({tag, "_done"}, {30'b0, busy, bus_valid}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_outs", {20'b0, busy, err, bus_valid, bus_we, bus_wstrb, load_data_ready, data_in}, 32'h0);
        check_eq("rst_bus", bus_addr | bus_wdata, 32'h0);
        rstn = 1'b1;

        do_load("lw", 3'b010, 32'h100, 32'hDEADBEEF, 3, 1'b0, 32'h100, 32'hDEADBEEF);
        do_load("lb", 3'b000, 32'h203, 32'h80FF1234, 1, 1'b0, 32'h200, 32'hFFFFFF80);
        do_load("lbu", 3'b100, 32'h203, 32'h80FF1234, 0, 1'b0, 32'h200, 32'h00000080);
        do_load("lh", 3'b001, 32'h102, 32'h80017FFF, 2, 1'b0, 32'h100, 32'hFFFF8001);
        do_load("lhu", 3'b101, 32'h102, 32'h80017FFF, 1, 1'b0, 32'h100, 32'h00008001);
        do_store("sb", 3'b000, 32'h301, 32'h000000A5, 5, 1'b0, 32'h300, 4'b0010, 32'hA5A5A5A5);
        do_store("sh_mis", 3'b001, 32'h101, 32'h00001234, 0, 1'b1, 32'h0, 4'b0000, 32'h0);
        do_store("sh", 3'b001, 32'h202, 32'h0000BEEF, 1, 1'b0, 32'h200, 4'b1100, 32'hBEEFBEEF);
        do_store("sw", 3'b010, 32'h104, 32'h12345678, 0, 1'b0, 32'h104, 4'b1111, 32'h12345678);
        do_load("ovr", 3'b010, 32'h040, 32'h0BADF00D, 3, 1'b1, 32'h040, 32'h0BADF00D);

        // Asynchronous reset while a load waits on the bus.
        @(negedge clk);
        address_ready = 1'b1; is_load = 1'b1; mem_op = 3'b010;
        @(negedge clk);
        address_ready = 1'b0; core_data = 32'h80;
        @(negedge clk);
        check_eq("rst_mid_valid", {31'b0, bus_valid}, 32'd1);
        #2 rstn = 1'b0;
        #1 check_eq("rst_mid_drop", {30'b0, busy, bus_valid}, 32'd0);
        @(negedge clk);
        rstn = 1'b1; is_load = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_idle", {30'b0, busy, bus_valid}, 32'd0);

        do_load("post_rst", 3'b101, 32'h102, 32'hC0DE0000, 0, 1'b0, 32'h100, 32'h0000C0DE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

endmodule
